muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 150 +++++++++++++++
 tb/tb_muldiv_unit.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: fixed 33-cycle latency, iterative shift-add multiply and
// restoring divide on operand magnitudes, with the sign applied when the result is delivered.
module muldiv_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic [4:0]  rd_in,
   output logic        busy,
   output logic        done,
   output logic        wb_we,
   output logic [4:0]  wb_rd,
   output logic [31:0] wb_data
);

   typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

   state_e      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [2:0]  op_q, op_d;
   logic [4:0]  rd_q, rd_d;
   logic [31:0] a_mag_q, a_mag_d, b_mag_q, b_mag_d;
   logic        a_neg_q, a_neg_d, b_neg_q, b_neg_d;
   logic [63:0] acc_q, acc_d;

   logic        a_signed, b_signed;
   logic [32:0] mul_sum, div_shift, div_diff;
   logic        div_ge;
   logic [63:0] prod;
   logic [31:0] quo, rem, a_val, result;

   always_comb begin
      a_signed = 1'b0;
      b_signed = 1'b0;
      unique case (funct3)
         3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
         3'b010:                         a_signed = 1'b1;
         default: ;
      endcase
   end

   // Low half of acc holds the multiplier (mul) or the dividend bits still to shift in (div)
   assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_mag_q} : 33'd0);
   assign div_shift = {acc_q[63:32], acc_q[31]};
   assign div_diff  = div_shift - {1'b0, b_mag_q};
   assign div_ge    = div_shift >= {1'b0, b_mag_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rd_d    = rd_q;
      a_mag_d = a_mag_q;
      b_mag_d = b_mag_q;
      a_neg_d = a_neg_q;
      b_neg_d = b_neg_q;
      acc_d   = acc_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StRun;
               cnt_d   = 5'd0;
               op_d    = funct3;
               rd_d    = rd_in;
               a_neg_d = a_signed & rs1_data[31];
               b_neg_d = b_signed & rs2_data[31];
               a_mag_d = a_neg_d ? (32'd0 - rs1_data) : rs1_data;
               b_mag_d = b_neg_d ? (32'd0 - rs2_data) : rs2_data;
               acc_d   = funct3[2] ? {32'd0, a_mag_d} : {32'd0, b_mag_d};
            end
         end
         StRun: begin
            cnt_d = cnt_q + 5'd1;
            if (op_q[2]) begin
               acc_d = {(div_ge ? div_diff[31:0] : div_shift[31:0]), acc_q[30:0], div_ge};
            end else begin
               acc_d = {mul_sum, acc_q[31:1]};
            end
            if (cnt_q == 5'd31) state_d = StDone;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         cnt_q   <= 5'd0;
         op_q    <= 3'd0;
         rd_q    <= 5'd0;
         a_mag_q <= 32'd0;
         b_mag_q <= 32'd0;
         a_neg_q <= 1'b0;
         b_neg_q <= 1'b0;
         acc_q   <= 64'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         a_mag_q <= a_mag_d;
         b_mag_q <= b_mag_d;
         a_neg_q <= a_neg_d;
         b_neg_q <= b_neg_d;
         acc_q   <= acc_d;
      end
   end

   assign prod  = (a_neg_q ^ b_neg_q) ? (64'd0 - acc_q) : acc_q;
   assign quo   = acc_q[31:0];
   assign rem   = acc_q[63:32];
   assign a_val = a_neg_q ? (32'd0 - a_mag_q) : a_mag_q;

   // Divide by zero overrides the natural restoring result so signed cases match RV32M
   always_comb begin
      result = 32'd0;
      unique case (op_q)
         3'b000:                 result = prod[31:0];
         3'b001, 3'b010, 3'b011: result = prod[63:32];
         3'b100, 3'b101: begin
            if (b_mag_q == 32'd0)         result = 32'hFFFF_FFFF;
            else if (a_neg_q ^ b_neg_q)   result = 32'd0 - quo;
            else                          result = quo;
         end
         default: begin
            if (b_mag_q == 32'd0)         result = a_val;
            else if (a_neg_q)             result = 32'd0 - rem;
            else                          result = rem;
         end
      endcase
   end

   always_comb begin
      busy    = (state_q != StIdle);
      done    = 1'b0;
      wb_we   = 1'b0;
      wb_rd   = 5'd0;
      wb_data = 32'd0;
      if (state_q == StDone) begin
         done    = 1'b1;
         wb_we   = (rd_q != 5'd0);
         wb_rd   = rd_q;
         wb_data = result;
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: results, latency, handshake and reset abort.
module tb_muldiv_unit;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [2:0]  funct3;
   logic [31:0] rs1_data, rs2_data;
   logic [4:0]  rd_in;
   logic        busy, done, wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;

   int checks = 0;
   int errors = 0;

   muldiv_unit dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .funct3   (funct3),
      .rs1_data (rs1_data),
      .rs2_data (rs2_data),
      .rd_in    (rd_in),
      .busy     (busy),
      .done     (done),
      .wb_we    (wb_we),
      .wb_rd    (wb_rd),
      .wb_data  (wb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Issue one op; inputs change right after accept. pulse_cyc != 0 re-pulses start mid-run.
   task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                         input int pulse_cyc);
      int cyc;
      int extra;
      @(negedge clk);
      funct3 = f; rs1_data = a; rs2_data = b; rd_in = rd; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; funct3 = ~f; rs1_data = ~a; rs2_data = b + 32'd1; rd_in = ~rd;
      cyc = 1;
      while (!done && cyc < 40) begin
         if (cyc == pulse_cyc) start = 1'b1;
         if (cyc == pulse_cyc + 1) start = 1'b0;
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, cyc, 33);
      check({tag, " data"}, wb_data, exp);
      check({tag, " we"}, {31'd0, wb_we}, {31'd0, rd != 5'd0});
      check({tag, " rd"}, {27'd0, wb_rd}, {27'd0, rd});
      start = 1'b0;
      @(negedge clk);
      check({tag, " post busy"}, {31'd0, busy}, 32'd0);
      if (pulse_cyc != 0) begin
         extra = 0;
         for (int i = 0; i < 40; i++) begin
            if (done) extra++;
            @(negedge clk);
         end
         check({tag, " extra done"}, extra, 0);
      end
   endtask

   initial begin
      int cyc;
      int ndone;
      rst_n = 1'b0; start = 1'b0; funct3 = 3'd0; rs1_data = 32'd0; rs2_data = 32'd0;
      rd_in = 5'd0;
      #12;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset done", {31'd0, done}, 32'd0);
      check("reset we", {31'd0, wb_we}, 32'd0);
      check("reset data", wb_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done || busy) ndone++;
      end
      check("release quiet", ndone, 0);

      run_op("mul",       3'b000, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 0);
      run_op("mulh",      3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 0);
      run_op("mulhu",     3'b011, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000, 0);
      run_op("mulhsu",    3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  32'hFFFF_FFFF, 0);
      run_op("div",       3'b100, 32'hFFFF_FFF9, 32'd2,         5'd9,  32'hFFFF_FFFD, 0);
      run_op("rem",       3'b110, 32'hFFFF_FFF9, 32'd2,         5'd10, 32'hFFFF_FFFF, 0);
      run_op("divu",      3'b101, 32'hFFFF_FFF9, 32'd2,         5'd11, 32'h7FFF_FFFC, 0);
      run_op("div0",      3'b100, 32'd5,         32'd0,         5'd12, 32'hFFFF_FFFF, 0);
      run_op("remu0",     3'b111, 32'd5,         32'd0,         5'd13, 32'd5,         0);
      run_op("rem0neg",   3'b110, 32'hFFFF_FFF9, 32'd0,         5'd14, 32'hFFFF_FFF9, 0);
      run_op("divovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15, 32'h8000_0000, 0);
      run_op("removf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0,         0);
      run_op("remu",      3'b111, 32'd100,       32'd7,         5'd17, 32'd2,         0);
      run_op("busystart", 3'b000, 32'd6,         32'd7,         5'd18, 32'd42,        10);
      run_op("rd0",       3'b000, 32'd2,         32'd3,         5'd0,  32'd6,         0);

      // Reset abort mid-run
      @(negedge clk);
      funct3 = 3'b000; rs1_data = 32'd9; rs2_data = 32'd9; rd_in = 5'd3; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1;
      while (cyc < 15) begin
         @(negedge clk);
         cyc++;
      end
      check("abort busy before", {31'd0, busy}, 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort busy", {31'd0, busy}, 32'd0);
      check("abort done", {31'd0, done}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ndone = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (done || wb_we) ndone++;
      end
      check("abort no done", ndone, 0);
      run_op("mul34", 3'b000, 32'd3, 32'd4, 5'd4, 32'd12, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
